// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: opcodes, FSM states
// and a constant-evaluable ceil(log2) helper for counter sizing.
package alu_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_alu_cell.sv
// One-bit ALU cell. Purely combinational; SUB is formed as a + ~b + 1, with the
// inversion of b done here and the +1 supplied through the initial carry.
module serial_alu_cell
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [3:0] op,
  output logic       r,
  output logic       c
);

  logic b_eff;

  // Bit result and carry for the selected operation; undefined ops give 0/0.
  always_comb begin
    b_eff = (op == OP_SUB) ? ~b : b;
    r     = 1'b0;
    c     = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_NOR: r = ~(a | b);
      OP_ADD, OP_SUB: begin
        r = a ^ b_eff ^ cin;
        c = (a & b_eff) | (a & cin) | (b_eff & cin);
      end
      default: begin
        r = 1'b0;
        c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: accepts an operand pair, runs it LSB-first through
// one serial_alu_cell (one bit per clock, registered carry between bits) and
// returns the reassembled word over a valid/ready handshake.
// Optional build macro SERIAL_ALU_OVF_EN adds a signed-overflow output `ovf`.
module serial_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter runs 0..WIDTH: WIDTH bit cycles plus one wrap-up cycle.
  localparam int CNT_W = clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MSB  = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [3:0]       op_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             cell_r;
  logic             cell_c;
`ifdef SERIAL_ALU_OVF_EN
  logic             ovf_bit;
`endif

  serial_alu_cell u_cell (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry),
    .op  (op_q),
    .r   (cell_r),
    .c   (cell_c)
  );

  // Sequencer FSM with shift registers and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
      zero      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      op_q      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
`ifdef SERIAL_ALU_OVF_EN
      ovf_bit   <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b;
            op_q     <= op;
            res_sr   <= '0;
            carry    <= (op == OP_SUB);
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
`ifdef SERIAL_ALU_OVF_EN
            ovf_bit  <= 1'b0;
`endif
          end else begin
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == CNT_END) begin
            // All bits done: publish the reassembled word.
            result    <= res_sr;
            cout      <= carry;
            zero      <= (res_sr == '0);
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SERIAL_ALU_OVF_EN
            ovf       <= ovf_bit;
`endif
          end else begin
            res_sr <= {cell_r, res_sr[WIDTH-1:1]};
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            carry  <= cell_c;
            cnt    <= cnt + 1'b1;
`ifdef SERIAL_ALU_OVF_EN
            // Signed overflow: carry into the MSB differs from carry out of it.
            if (cnt == CNT_MSB && (op_q == OP_ADD || op_q == OP_SUB))
              ovf_bit <= carry ^ cell_c;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq at WIDTH=8: a vector table for the
// opcode behaviour plus hand-written backpressure, input-hazard and
// mid-operation reset sequences. Checks ovf when SERIAL_ALU_OVF_EN is defined.
module tb_serial_alu_seq;

  localparam int W = 8;
  localparam logic [3:0] O_AND = 4'b0000;
  localparam logic [3:0] O_OR  = 4'b0001;
  localparam logic [3:0] O_ADD = 4'b0010;
  localparam logic [3:0] O_SUB = 4'b0110;
  localparam logic [3:0] O_NOR = 4'b1100;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;
`ifdef SERIAL_ALU_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] res;
    logic         cout;
    logic         zero;
    logic         ovf;
  } vec_t;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .zero      (zero)
`ifdef SERIAL_ALU_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, then present one request for the accept edge.
  task automatic start_req(input string tag, input logic [W-1:0] va,
                           input logic [W-1:0] vb, input logic [3:0] vop);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, " in_ready_before"}, in_ready, 1);
    a = va;
    b = vb;
    op = vop;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Count cycles from the accept edge until out_valid is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " out_valid_drop"}, out_valid, 0);
    check({tag, " in_ready_back"}, in_ready, 1);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int n;
    start_req(tag, v.a, v.b, v.op);
    wait_done(n);
    check({tag, " latency"}, n, W + 1);
    check({tag, " result"}, result, v.res);
    check({tag, " cout"}, cout, v.cout);
    check({tag, " zero"}, zero, v.zero);
`ifdef SERIAL_ALU_OVF_EN
    check({tag, " ovf"}, ovf, v.ovf);
`endif
    release_result(tag);
  endtask

  initial begin
    vec_t vecs[9];
    int n;
    bit stable;
    logic [W-1:0] r0;
    logic c0;
    logic z0;

    vecs[0] = '{a: 8'hFF, b: 8'h01, op: O_ADD,   res: 8'h00, cout: 1'b1, zero: 1'b1, ovf: 1'b0};
    vecs[1] = '{a: 8'h05, b: 8'h07, op: O_SUB,   res: 8'hFE, cout: 1'b0, zero: 1'b0, ovf: 1'b0};
    vecs[2] = '{a: 8'h80, b: 8'h01, op: O_SUB,   res: 8'h7F, cout: 1'b1, zero: 1'b0, ovf: 1'b1};
    vecs[3] = '{a: 8'hF0, b: 8'h3C, op: O_AND,   res: 8'h30, cout: 1'b0, zero: 1'b0, ovf: 1'b0};
    vecs[4] = '{a: 8'hF0, b: 8'h3C, op: O_OR,    res: 8'hFC, cout: 1'b0, zero: 1'b0, ovf: 1'b0};
    vecs[5] = '{a: 8'hF0, b: 8'h3C, op: O_NOR,   res: 8'h03, cout: 1'b0, zero: 1'b0, ovf: 1'b0};
    vecs[6] = '{a: 8'hF0, b: 8'h3C, op: 4'b0011, res: 8'h00, cout: 1'b0, zero: 1'b1, ovf: 1'b0};
    vecs[7] = '{a: 8'h7F, b: 8'h01, op: O_ADD,   res: 8'h80, cout: 1'b0, zero: 1'b0, ovf: 1'b1};
    vecs[8] = '{a: 8'h09, b: 8'h09, op: O_SUB,   res: 8'h00, cout: 1'b1, zero: 1'b1, ovf: 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    op = '0;

    // Reset state
    repeat (3) tick();
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst result", result, 0);
    check("rst cout", cout, 0);
    check("rst zero", zero, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst in_ready", in_ready, 1);

    // out_ready high before any result has no effect
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("early out_ready out_valid", out_valid, 0);

    // Opcode table
    for (int i = 0; i < 9; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Backpressure: result held 20 cycles with in_ready low
    start_req("bp", 8'h12, 8'h34, O_ADD);
    wait_done(n);
    check("bp latency", n, W + 1);
    r0 = result;
    c0 = cout;
    z0 = zero;
    check("bp result", r0, 8'h46);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (result !== r0 || cout !== c0 || zero !== z0 || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    check("bp held", stable, 1);
    release_result("bp");

    // Input hazard: inputs change and in_valid pulses during RUN
    start_req("haz", 8'h0F, 8'h01, O_ADD);
    repeat (3) tick();
    check("haz in_ready_run", in_ready, 0);
    a = 8'hAA;
    b = 8'h55;
    op = O_OR;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done(n);
    check("haz result", result, 8'h10);
    check("haz cout", cout, 0);
    release_result("haz");
    stable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stable = 1'b0;
    end
    check("haz no_second", stable, 1);

    // Reset during RUN aborts the operation
    start_req("mrst", 8'h33, 8'h44, O_ADD);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("mrst in_ready", in_ready, 0);
    check("mrst out_valid", out_valid, 0);
    check("mrst result", result, 0);
    check("mrst cout", cout, 0);
    check("mrst zero", zero, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("mrst in_ready_after", in_ready, 1);
    check("mrst out_valid_after", out_valid, 0);
    run_vec("after_rst", '{a: 8'h12, b: 8'h34, op: O_ADD, res: 8'h46, cout: 1'b0, zero: 1'b0, ovf: 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
